// File: rtl/joystick_reader.sv
// ============================================================================
// joystick_reader : polls a 4021-style serial pad and publishes a button byte
// Revision 1.0
// ============================================================================
`default_nettype none

module joystick_reader #(
    parameter int CLK_DIV = 81
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       read_ack,
    input  logic       joy_data,
    output logic       joy_latch,
    output logic       joy_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [10:0] C_LATCH_LOAD = 11'(2 * CLK_DIV - 1);
    localparam logic [10:0] C_PHASE_LOAD = 11'(CLK_DIV - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [10:0] r_count;
    logic [10:0] w_next_count;
    logic [2:0]  r_index;
    logic [2:0]  w_next_index;
    logic [7:0]  r_shift;
    logic [7:0]  w_next_shift;
    logic [1:0]  r_sync;
    logic        w_latch_next;
    logic        w_clk_next;
    logic        w_busy_next;
    logic        w_publish;

    // State register, datapath and registered outputs
    always_ff @(posedge raw_clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= 11'd0;
            r_index   <= 3'd0;
            r_shift   <= 8'd0;
            r_sync    <= 2'b11;
            joy_latch <= 1'b0;
            joy_clk   <= 1'b1;
            busy      <= 1'b0;
            buttons   <= 8'd0;
            valid     <= 1'b0;
            changed   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            r_index   <= w_next_index;
            r_shift   <= w_next_shift;
            r_sync    <= {r_sync[0], joy_data};
            joy_latch <= w_latch_next;
            joy_clk   <= w_clk_next;
            busy      <= w_busy_next;
            changed   <= w_publish && (r_shift != buttons);
            if (w_publish) begin
                buttons <= r_shift;
            end
            // New data wins over a simultaneous acknowledge
            if (w_publish) begin
                valid <= 1'b1;
            end else if (read_ack) begin
                valid <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_index = r_index;
        w_next_shift = r_shift;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LATCH;
                    w_next_count = C_LATCH_LOAD;
                    w_next_index = 3'd0;
                    w_next_shift = 8'd0;
                end
            end
            S_LATCH: begin
                if (r_count == 11'd0) begin
                    w_next_state = S_LOW;
                    w_next_count = C_PHASE_LOAD;
                end else begin
                    w_next_count = r_count - 11'd1;
                end
            end
            S_LOW: begin
                if (r_count == 11'd0) begin
                    w_next_shift[r_index] = ~r_sync[1];
                    w_next_state          = S_HIGH;
                    w_next_count          = C_PHASE_LOAD;
                end else begin
                    w_next_count = r_count - 11'd1;
                end
            end
            S_HIGH: begin
                if (r_count == 11'd0) begin
                    if (r_index == 3'd7) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_index = r_index + 3'd1;
                        w_next_state = S_LOW;
                        w_next_count = C_PHASE_LOAD;
                    end
                end else begin
                    w_next_count = r_count - 11'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the pins are registered
    always_comb begin
        w_latch_next = (w_next_state == S_LATCH);
        w_clk_next   = (w_next_state != S_LOW);
        w_busy_next  = (w_next_state == S_LATCH) || (w_next_state == S_LOW) ||
                       (w_next_state == S_HIGH);
        w_publish    = (r_state == S_HIGH) && (w_next_state == S_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_joystick_reader.sv
// ============================================================================
// tb_joystick_reader : directed table-driven bench with a 4021 pad model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_joystick_reader;

    logic       raw_clk = 1'b0;
    logic [1:0] reset_v = 2'b00;
    logic [1:0] start_v = 2'b00;
    logic [1:0] ack_v   = 2'b00;
    wire  [1:0] data_w;
    wire  [1:0] latch_w;
    wire  [1:0] clk_w;
    wire  [1:0] valid_w;
    wire  [1:0] changed_w;
    wire  [1:0] busy_w;
    wire  [7:0] btn0;
    wire  [7:0] btn1;

    logic [7:0] pad [2]      = '{8'h00, 8'h00};
    logic [7:0] sr  [2]      = '{8'hFF, 8'hFF};
    logic       prev_clk [2] = '{1'b1, 1'b1};

    int errors = 0;
    int checks = 0;

    always #5 raw_clk = ~raw_clk;

    joystick_reader #(.CLK_DIV(4)) dut0 (
        .raw_clk (raw_clk),  .reset (reset_v[0]), .start (start_v[0]),
        .read_ack(ack_v[0]), .joy_data(data_w[0]), .joy_latch(latch_w[0]),
        .joy_clk (clk_w[0]), .buttons(btn0),       .valid (valid_w[0]),
        .changed (changed_w[0]), .busy(busy_w[0])
    );

    joystick_reader #(.CLK_DIV(81)) dut1 (
        .raw_clk (raw_clk),  .reset (reset_v[1]), .start (start_v[1]),
        .read_ack(ack_v[1]), .joy_data(data_w[1]), .joy_latch(latch_w[1]),
        .joy_clk (clk_w[1]), .buttons(btn1),       .valid (valid_w[1]),
        .changed (changed_w[1]), .busy(busy_w[1])
    );

    // 4021 model: parallel load while latched, shift on joy_clk rising edge
    always @(posedge raw_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (latch_w[d]) begin
                sr[d] <= ~pad[d];
            end else if (clk_w[d] && !prev_clk[d]) begin
                sr[d] <= {1'b1, sr[d][7:1]};
            end
            prev_clk[d] <= clk_w[d];
        end
    end
    assign data_w[0] = sr[0][0];
    assign data_w[1] = sr[1][0];

    function automatic logic [7:0] btn(input int d);
        return (d == 0) ? btn0 : btn1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         d;
        logic [7:0] pat;
        int         inject_at;
        bit         ack_at_done;
        bit         ack_after;
        logic [7:0] exp_buttons;
        logic       exp_changed;
    } scan_vec_t;

    task automatic run_scan(input int d, input logic [7:0] pat, input int inject_at,
                            input bit ack_at_done, output int done_k, output int latch_n,
                            output int rises, output int chg_n, output logic [7:0] btn_at,
                            output logic valid_at, output logic chg_at, output logic valid_end);
        int   c;
        int   limit;
        logic pclk;
        c      = (d == 0) ? 4 : 81;
        limit  = 18 * c + 6;
        pad[d] = pat;
        done_k = -1; latch_n = 0; rises = 0; chg_n = 0;
        btn_at = 8'hXX; valid_at = 1'bx; chg_at = 1'bx;
        @(negedge raw_clk);
        start_v[d] = 1'b1;
        pclk = clk_w[d];
        for (int k = 1; k <= limit; k++) begin
            @(negedge raw_clk);
            start_v[d] = (k == inject_at);
            ack_v[d]   = ack_at_done && (k == 18 * c);
            if (latch_w[d]) latch_n++;
            if (clk_w[d] && !pclk) rises++;
            pclk = clk_w[d];
            if (changed_w[d]) chg_n++;
            if (done_k < 0 && k > 1 && !busy_w[d]) begin
                done_k   = k;
                btn_at   = btn(d);
                valid_at = valid_w[d];
                chg_at   = changed_w[d];
            end
        end
        valid_end  = valid_w[d];
        start_v[d] = 1'b0;
        ack_v[d]   = 1'b0;
    endtask

    task automatic scan_and_check(input scan_vec_t v);
        int         done_k, latch_n, rises, chg_n, c;
        logic [7:0] btn_at;
        logic       valid_at, chg_at, valid_end;
        c = (v.d == 0) ? 4 : 81;
        run_scan(v.d, v.pat, v.inject_at, v.ack_at_done, done_k, latch_n, rises, chg_n,
                 btn_at, valid_at, chg_at, valid_end);
        chk($sformatf("latency d%0d pat%02h", v.d, v.pat), done_k, 18 * c + 1);
        chk($sformatf("latch_len d%0d pat%02h", v.d, v.pat), latch_n, 2 * c);
        chk($sformatf("clk_rises d%0d pat%02h", v.d, v.pat), rises, 8);
        chk($sformatf("buttons d%0d pat%02h", v.d, v.pat), btn_at, v.exp_buttons);
        chk($sformatf("valid d%0d pat%02h", v.d, v.pat), valid_at, 1);
        chk($sformatf("changed d%0d pat%02h", v.d, v.pat), chg_at, v.exp_changed);
        chk($sformatf("changed_pulses d%0d pat%02h", v.d, v.pat), chg_n, v.exp_changed ? 1 : 0);
        chk($sformatf("valid_hold d%0d pat%02h", v.d, v.pat), valid_end, 1);
        if (v.ack_after) begin
            @(negedge raw_clk);
            ack_v[v.d] = 1'b1;
            @(negedge raw_clk);
            ack_v[v.d] = 1'b0;
            chk($sformatf("ack_clears d%0d", v.d), valid_w[v.d], 0);
        end
    endtask

    scan_vec_t vecs [6];

    initial begin
        int         done_k, latch_n, rises, chg_n;
        logic [7:0] btn_at;
        logic       valid_at, chg_at, valid_end;
        scan_vec_t  v;

        vecs[0] = '{0, 8'hA5, 0,  1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[1] = '{0, 8'hA5, 0,  1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{0, 8'h5A, 20, 1'b1, 1'b0, 8'h5A, 1'b1};
        vecs[3] = '{1, 8'h01, 0,  1'b0, 1'b0, 8'h01, 1'b1};
        vecs[4] = '{1, 8'h80, 0,  1'b0, 1'b0, 8'h80, 1'b1};
        vecs[5] = '{0, 8'h00, 0,  1'b0, 1'b0, 8'h00, 1'b1};

        // Reset and idle behaviour
        reset_v = 2'b00;
        repeat (3) @(negedge raw_clk);
        reset_v = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge raw_clk);
            chk("idle d0", {latch_w[0], clk_w[0], btn0, valid_w[0], changed_w[0], busy_w[0]},
                {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        chk("idle d1", {latch_w[1], clk_w[1], btn1, valid_w[1], changed_w[1], busy_w[1]},
            {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 6; i++) begin
            scan_and_check(vecs[i]);
        end

        // Reset in the middle of a scan
        pad[0] = 8'hFF;
        @(negedge raw_clk);
        start_v[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge raw_clk);
            start_v[0] = 1'b0;
        end
        chk("midscan busy before reset", busy_w[0], 1);
        reset_v[0] = 1'b0;
        @(negedge raw_clk);
        chk("reset latch", latch_w[0], 0);
        chk("reset clk", clk_w[0], 1);
        chk("reset busy", busy_w[0], 0);
        chk("reset buttons", btn0, 8'h00);
        chk("reset valid", valid_w[0], 0);
        reset_v[0] = 1'b1;
        repeat (4) @(negedge raw_clk);
        chk("no partial publish", {btn0, valid_w[0]}, {8'h00, 1'b0});

        v = '{0, 8'h3C, 0, 1'b0, 1'b0, 8'h3C, 1'b1};
        scan_and_check(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
